vga_mode_seq: RTL and testbench
===============================

VGA_MODE_SEQ -- requirements
Module: vga_mode_seq

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, meaning the number of VGA pixel sources (2..16).
REQ-002 The block SHALL have parameter COLOR_W, default 12, meaning the RGB bits per pixel.
REQ-003 The block SHALL have parameter BLANK_FRAMES, default 1, meaning the black frames inserted per switch (0..15).
REQ-004 The block SHALL have parameter AUTO_FRAMES, default 600, meaning the frames between auto-advances (>=1).
REQ-005 The block SHALL have parameter DEF_MODE, default 0, meaning the mode selected after reset.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the pixel clock, the only clock.
REQ-007 The block SHALL have port rst_n_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The block SHALL have port src_rgb_i, input, N_SRC*COLOR_W bits: source k in bits [k*COLOR_W +: COLOR_W].
REQ-009 The block SHALL have ports hsync_i, vsync_i and de_i, inputs, 1 bit each: shared timing; syncs active-low.
REQ-010 The block SHALL have port mode_i, input, MODE_W=$clog2(N_SRC) bits: the requested mode.
REQ-011 The block SHALL have port mode_load_i, input, 1 bit: a one-cycle strobe that requests mode_i.
REQ-012 The block SHALL have port next_i, input, 1 bit: a one-cycle strobe that requests the next mode.
REQ-013 The block SHALL have port auto_en_i, input, 1 bit: the auto-cycle enable.
REQ-014 The block SHALL have ports rgb_o (COLOR_W bits) and hsync_o, vsync_o, de_o (1 bit each), outputs: the muxed VGA stream.
REQ-015 The block SHALL have port mode_o, output, MODE_W bits: the mode currently displayed.
REQ-016 The block SHALL have port switching_o, output, 1 bit: high in the PEND or BLANK state.

Function
REQ-017 Frame boundary SHALL be a falling edge of vsync_i, detected from a registered copy of vsync_i.
REQ-018 rgb_o, hsync_o, vsync_o and de_o SHALL have exactly 1 cycle latency from their inputs; timing outputs are never gated.
REQ-019 rgb_o SHALL be src[mode_o] when registered de is high and state is SHOW or PEND; otherwise it SHALL be 0.
REQ-020 mode_load_i SHALL request mode_i; next_i SHALL request (mode_o+1) mod N_SRC, wrapping from N_SRC-1 to 0.
REQ-021 When mode_load_i and next_i are high in the same cycle, mode_load_i SHALL take priority.
REQ-022 A request with mode_i >= N_SRC SHALL be ignored, as SHALL a request equal to mode_o while in SHOW.
REQ-023 The FSM SHALL have states SHOW, PEND and BLANK; SHOW goes to PEND on a valid request, and pending_mode is latched.
REQ-024 A new request in PEND SHALL overwrite pending_mode; if it equals mode_o, the FSM SHALL return to SHOW.
REQ-025 On a boundary in PEND, mode_o SHALL be set to pending_mode and the FSM SHALL enter BLANK, or SHOW if BLANK_FRAMES=0.
REQ-026 BLANK SHALL count boundaries and return to SHOW on the BLANK_FRAMES-th boundary after entry.
REQ-027 A request during BLANK SHALL be latched and, if still different from mode_o, SHALL move the FSM to PEND on exit.
REQ-028 A mode change SHALL occur only at a boundary; mode_o SHALL never change mid-frame.

Reset
REQ-029 While rst_n_i is low, all outputs SHALL be 0 except mode_o=DEF_MODE; state SHALL be SHOW and all counters and pending requests 0.
REQ-030 Reset asserted mid-switch SHALL abandon the pending request; after deassertion, the first boundary SHALL be detected fresh.

Configuration
REQ-031 With MODE_AUTO_CYCLE_EN defined, a frame counter SHALL count boundaries in SHOW while auto_en_i=1 and issue an internal next at AUTO_FRAMES.
REQ-032 With MODE_AUTO_CYCLE_EN defined, the counter SHALL clear on any accepted request, on a mode change, or when auto_en_i=0.
REQ-033 With MODE_AUTO_CYCLE_EN defined, a manual strobe in the same cycle as the internal next SHALL win.
REQ-034 Without MODE_AUTO_CYCLE_EN, no counter SHALL exist, auto_en_i SHALL be ignored, and behaviour SHALL be otherwise identical.

Structure
REQ-035 Package vga_seq_pkg SHALL hold the state enum (SHOW, PEND, BLANK) and the BLANK/auto counter width constants.
REQ-036 Sub-module vga_frame_edge SHALL register vsync_i and output a one-cycle frame_start pulse.

Verification
REQ-037 With N_SRC=4 and mode_o=1, a mode_load_i pulse with mode_i=3 mid-frame SHALL keep mode_o=1 until the next vsync fall, then one black frame, then source 3 pixels.
REQ-038 With mode_o=3, a next_i pulse SHALL give mode_o=0 after the boundary, and switching_o SHALL be high from the strobe+1 until the end of BLANK.
REQ-039 Simultaneous mode_load_i (mode_i=2) and next_i from mode 0 SHALL give mode_o=2; a later mode_i=5 request SHALL be ignored, with no state change.
REQ-040 With BLANK_FRAMES=0, a request SHALL switch directly at the boundary, with no black frame.
REQ-041 With MODE_AUTO_CYCLE_EN, AUTO_FRAMES=3 and auto_en_i=1, mode_o SHALL advance every 3+BLANK_FRAMES frames; a manual next_i SHALL restart the count.
REQ-042 rst_n_i low during BLANK SHALL immediately give mode_o=DEF_MODE, rgb_o=0 and switching_o=0.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// vga_seq_pkg: shared state encoding and counter widths for the VGA mode sequencer
package vga_seq_pkg;
  typedef enum logic [1:0] {SHOW, PEND, BLANK} state_t;
  localparam int BLANK_CNT_W = 4;
  localparam int AUTO_CNT_W = 16;
endpackage

// File: rtl/vga_frame_edge.sv
// vga_frame_edge: registers vsync and flags its falling edge as a frame start
module vga_frame_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vsync_i,
  output logic vsync_r,
  output logic frame_start
);
  // one-cycle vsync delay; cleared in reset so the first fall afterwards is seen fresh
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) vsync_r <= 1'b0;
    else vsync_r <= vsync_i;
  assign frame_start = vsync_r & ~vsync_i;
endmodule

// File: rtl/vga_mode_seq.sv
// vga_mode_seq: frame-synchronous VGA source selector with black-frame insertion; MODE_AUTO_CYCLE_EN adds auto-advance
module vga_mode_seq
  import vga_seq_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int COLOR_W      = 12,
  parameter int BLANK_FRAMES = 1,
  parameter int AUTO_FRAMES  = 600,
  parameter int DEF_MODE     = 0,
  localparam int MODE_W      = $clog2(N_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_SRC*COLOR_W-1:0] src_rgb_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic                     de_i,
  input  logic [MODE_W-1:0]        mode_i,
  input  logic                     mode_load_i,
  input  logic                     next_i,
  input  logic                     auto_en_i,
  output logic [COLOR_W-1:0]       rgb_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     de_o,
  output logic [MODE_W-1:0]        mode_o,
  output logic                     switching_o
);
  state_t state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d, pend_q, pend_d, nxt, req_mode, eff;
  logic [BLANK_CNT_W-1:0] blank_q, blank_d;
  logic [COLOR_W-1:0] rgb_q;
  logic frame_start, vs_r, hs_q, de_q, req, acc, auto_fire, blank_last;

  vga_frame_edge u_edge (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .vsync_i    (vsync_i),
    .vsync_r    (vs_r),
    .frame_start(frame_start)
  );

  // an explicit load outranks next/auto; an out-of-range load is dropped entirely
  assign nxt        = (mode_q == MODE_W'(N_SRC - 1)) ? '0 : mode_q + 1'b1;
  assign req        = mode_load_i ? (32'(mode_i) < N_SRC) : (next_i || auto_fire);
  assign req_mode   = mode_load_i ? mode_i : nxt;
  assign eff        = req ? req_mode : pend_q;
  assign acc        = req && (state_q != SHOW || req_mode != mode_q);
  assign blank_last = blank_q == BLANK_CNT_W'(BLANK_FRAMES - 1);

`ifdef MODE_AUTO_CYCLE_EN
  logic [AUTO_CNT_W-1:0] auto_q;
  assign auto_fire = auto_en_i && state_q == SHOW && auto_q == AUTO_CNT_W'(AUTO_FRAMES - 1);
  // counts shown frames; firing one frame early lets the switch land on the AUTO_FRAMES-th boundary
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) auto_q <= '0;
    else if (!auto_en_i || acc || mode_d != mode_q) auto_q <= '0;
    else if (state_q == SHOW && frame_start && !auto_fire) auto_q <= auto_q + 1'b1;
`else
  logic unused_auto;
  assign unused_auto = auto_en_i | (AUTO_FRAMES == 0);
  assign auto_fire = 1'b0;
`endif

  // next-state logic; pend tracks mode after a switch so a stale value never re-triggers
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    blank_d = blank_q;
    case (state_q)
      SHOW: if (acc) begin
        state_d = PEND;
        pend_d  = req_mode;
      end
      PEND: begin
        pend_d = eff;
        if (req && req_mode == mode_q) state_d = SHOW;
        else if (frame_start) begin
          mode_d  = eff;
          state_d = (BLANK_FRAMES == 0) ? SHOW : BLANK;
          blank_d = '0;
        end
      end
      BLANK: begin
        pend_d = eff;
        if (frame_start) begin
          blank_d = blank_last ? '0 : blank_q + 1'b1;
          if (blank_last) state_d = (eff != mode_q) ? PEND : SHOW;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // sequencer state
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= SHOW;
      mode_q  <= MODE_W'(DEF_MODE);
      pend_q  <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
    end

  // one-cycle pixel pipeline; colour forced black outside active video and during BLANK
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      hs_q  <= 1'b0;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hsync_i;
      de_q  <= de_i;
      rgb_q <= (de_i && state_q != BLANK) ? src_rgb_i[int'(mode_q)*COLOR_W +: COLOR_W] : '0;
    end

  assign rgb_o       = rgb_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_r;
  assign de_o        = de_q;
  assign mode_o      = mode_q;
  assign switching_o = state_q != SHOW;
endmodule

// File: tb/tb_vga_mode_seq.sv
// tb_vga_mode_seq: scoreboard bench driving tiny VGA frames into a 4-source/1-blank and a 6-source/0-blank sequencer
module tb_vga_mode_seq;
  logic clk = 0, rst_n = 0, hsync = 1, vsync = 1, de = 0, load = 0, nxt = 0, auto_en = 1;
  logic [2:0] mi = '0;
  logic [71:0] src = '0;
  logic [11:0] m_rgb, z_rgb;
  logic m_hs, m_vs, m_de, m_sw, z_hs, z_vs, z_de, z_sw;
  logic [1:0] m_mode;
  logic [2:0] z_mode;
  logic hs_p, vs_p, de_p, rn_p;
  int checks = 0, errors = 0, p = 0;

  typedef struct {logic [11:0] rm; logic [1:0] mm; logic [11:0] rz; logic [2:0] mz;} exp_t;
  typedef struct {int l1, m1, n1, l2, m2, n2, mm, bk, mz, sm, sz;} fr_t;
  exp_t q[$];
  fr_t tab[22];

  always #5 clk = ~clk;

  vga_mode_seq #(.N_SRC(4), .COLOR_W(12), .BLANK_FRAMES(1), .AUTO_FRAMES(600), .DEF_MODE(0)) dut_m (
    .clk_i(clk), .rst_n_i(rst_n), .src_rgb_i(src[47:0]), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
    .mode_i(mi[1:0]), .mode_load_i(load), .next_i(nxt), .auto_en_i(auto_en),
    .rgb_o(m_rgb), .hsync_o(m_hs), .vsync_o(m_vs), .de_o(m_de), .mode_o(m_mode), .switching_o(m_sw));

  vga_mode_seq #(.N_SRC(6), .COLOR_W(12), .BLANK_FRAMES(0), .AUTO_FRAMES(600), .DEF_MODE(0)) dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .src_rgb_i(src), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
    .mode_i(mi), .mode_load_i(load), .next_i(nxt), .auto_en_i(auto_en),
    .rgb_o(z_rgb), .hsync_o(z_hs), .vsync_o(z_vs), .de_o(z_de), .mode_o(z_mode), .switching_o(z_sw));

`ifdef MODE_AUTO_CYCLE_EN
  logic [11:0] a_rgb;
  logic a_hs, a_vs, a_de, a_sw;
  logic [1:0] a_mode;
  vga_mode_seq #(.N_SRC(4), .COLOR_W(12), .BLANK_FRAMES(1), .AUTO_FRAMES(3), .DEF_MODE(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .src_rgb_i(src[47:0]), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
    .mode_i(2'd0), .mode_load_i(1'b0), .next_i(1'b0), .auto_en_i(1'b1),
    .rgb_o(a_rgb), .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .mode_o(a_mode), .switching_o(a_sw));
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [11:0] px(input int k, input int pv);
    px = {1'b1, 3'(k), 8'(pv)};
  endfunction

  // one frame: 4 lines of 10 clocks, line 0 carries vsync, de on clocks 2..7 of lines 1..3
  task automatic run_frame(input int f, input fr_t r);
    exp_t e;
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (l == 3 && c == 9) begin
          chk($sformatf("m_switching_f%0d", f), 32'(m_sw), 32'(r.sm));
          chk($sformatf("z_switching_f%0d", f), 32'(z_sw), 32'(r.sz));
`ifdef MODE_AUTO_CYCLE_EN
          if (f <= 20) chk($sformatf("a_mode_f%0d", f), 32'(a_mode), 32'(f < 2 ? 0 : ((f + 2) / 4) % 4));
`endif
        end
        vsync = l != 0;
        hsync = c < 8;
        de = l != 0 && c >= 2 && c < 8;
        load = (l == 1 && c == 5 && r.l1 != 0) || (l == 2 && c == 5 && r.l2 != 0);
        nxt = (l == 1 && c == 5 && r.n1 != 0) || (l == 2 && c == 5 && r.n2 != 0);
        mi = 3'(l == 1 ? r.m1 : r.m2);
        p++;
        for (int k = 0; k < 6; k++) src[k*12 +: 12] = px(k, p);
        if (de) begin
          e.rm = r.bk != 0 ? 12'h0 : px(r.mm, p);
          e.mm = 2'(r.mm);
          e.rz = px(r.mz, p);
          e.mz = 3'(r.mz);
          q.push_back(e);
        end
      end
  endtask

  always @(posedge clk) begin
    hs_p <= hsync;
    vs_p <= vsync;
    de_p <= de;
    rn_p <= rst_n;
  end

  // monitor: timing passthrough every cycle, scoreboard pop on every displayed pixel
  always @(negedge clk)
    if (rst_n && rn_p) begin
      exp_t e;
      chk("m_timing", 32'({m_hs, m_vs, m_de}), 32'({hs_p, vs_p, de_p}));
      chk("z_timing", 32'({z_hs, z_vs, z_de}), 32'({hs_p, vs_p, de_p}));
      if (m_de) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow got pixel %0h expected none", m_rgb);
        end else begin
          e = q.pop_front();
          chk("m_rgb", 32'(m_rgb), 32'(e.rm));
          chk("m_mode", 32'(m_mode), 32'(e.mm));
          chk("z_rgb", 32'(z_rgb), 32'(e.rz));
          chk("z_mode", 32'(z_mode), 32'(e.mz));
        end
      end else begin
        chk("m_rgb_idle", 32'(m_rgb), 32'h0);
        chk("z_rgb_idle", 32'(z_rgb), 32'h0);
      end
    end

  initial begin
    tab = '{
      '{1,1,0, 0,0,0, 0,0,0, 1,1},
      '{0,0,0, 0,0,0, 1,1,1, 1,0},
      '{1,3,0, 0,0,0, 1,0,1, 1,1},
      '{0,0,0, 0,0,0, 3,1,3, 1,0},
      '{0,0,1, 0,0,0, 3,0,3, 1,1},
      '{0,0,0, 0,0,0, 0,1,4, 1,0},
      '{1,2,1, 0,0,0, 0,0,4, 1,1},
      '{0,0,0, 0,0,0, 2,1,2, 1,0},
      '{1,6,0, 0,0,0, 2,0,2, 0,0},
      '{0,0,0, 0,0,0, 2,0,2, 0,0},
      '{1,1,0, 1,2,0, 2,0,2, 0,0},
      '{1,0,0, 0,0,1, 2,0,2, 1,1},
      '{1,1,0, 0,0,0, 3,1,3, 1,1},
      '{0,0,0, 0,0,0, 3,0,1, 1,0},
      '{0,0,0, 0,0,0, 1,1,1, 1,0},
      '{1,5,0, 0,0,0, 1,0,1, 0,1},
      '{0,0,1, 0,0,0, 1,0,5, 1,1},
      '{0,0,0, 0,0,0, 2,1,0, 1,0},
      '{0,0,0, 0,0,0, 2,0,0, 0,0},
      '{1,3,0, 0,0,0, 2,0,0, 1,1},
      '{0,0,0, 0,0,0, 3,1,3, 1,0},
      '{0,0,0, 0,0,0, 0,0,0, 0,0}
    };
    #12;
    chk("rst_rgb", 32'(m_rgb), 32'h0);
    chk("rst_sync", 32'({m_hs, m_vs, m_de}), 32'h0);
    chk("rst_mode", 32'(m_mode), 32'h0);
    chk("rst_switching", 32'(m_sw), 32'h0);
    chk("rst_z_mode", 32'(z_mode), 32'h0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 22; f++) begin
      if (f == 21) begin
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("blank_rst_mode", 32'(m_mode), 32'h0);
        chk("blank_rst_rgb", 32'(m_rgb), 32'h0);
        chk("blank_rst_switching", 32'(m_sw), 32'h0);
        chk("blank_rst_z_mode", 32'(z_mode), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
      end
      run_frame(f, tab[f]);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
